connect_arbiter: RTL and testbench
==================================

CONNECT_ARBITER -- requirements
Module: connect_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default PACKET_WIDTH (from include/param.vh), gives the width of one packet.
REQ-002 Parameter CONNECT_NUM, default 3, gives the number of requester ports; the legal range is 2..16.
REQ-003 Local parameter SRC_WIDTH = clog2(CONNECT_NUM), with a minimum of 1, gives the width of the source index.
REQ-004 CLK  input  1  -- the single clock; all state changes on the rising edge.
REQ-005 RST  input  1  -- synchronous reset, active-high.
REQ-006 RECEIVE_VALID  input  CONNECT_NUM  -- per-requester packet valid.
REQ-007 RECEIVE_READY  output  CONNECT_NUM  -- per-requester accept; at most one bit is high in any cycle.
REQ-008 RECEIVE_DATA  input  DATA_WIDTH*CONNECT_NUM  -- requester i's packet occupies bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
REQ-009 SEND_VALID  output  1  -- the output register holds a packet.
REQ-010 SEND_READY  input  1  -- the downstream consumer accepts the packet.
REQ-011 SEND_DATA  output  DATA_WIDTH  -- the registered packet.
REQ-012 SEND_SOURCE  output  SRC_WIDTH  -- index of the requester that supplied SEND_DATA.

Function
REQ-013 A transfer shall occur on any port when VALID and READY are both high at a rising edge of CLK.
REQ-014 The block shall hold a one-entry output register (SEND_VALID, SEND_DATA, SEND_SOURCE) plus a round-robin pointer LAST of width SRC_WIDTH.
REQ-015 The accept condition shall be ACCEPT = !SEND_VALID || SEND_READY; this is combinational from SEND_READY and permits one packet per cycle.
REQ-016 The grant shall be the first index i with RECEIVE_VALID[i]=1, searching LAST+1, LAST+2, ... modulo CONNECT_NUM and ending with LAST itself.
REQ-017 RECEIVE_READY[g] shall be 1 only when ACCEPT=1, RST=0 and g is the grant; all other RECEIVE_READY bits shall be 0.
REQ-018 RECEIVE_READY shall not depend on RECEIVE_VALID of the port it drives, other than through the grant search.
REQ-019 On an input transfer from requester g, at the next edge: SEND_DATA <= slice g, SEND_SOURCE <= g, SEND_VALID <= 1, LAST <= g.
REQ-020 On ACCEPT=1 with no requester valid, at the next edge: SEND_VALID <= SEND_VALID && !SEND_READY (it becomes 0 once the held packet leaves), and LAST is unchanged.
REQ-021 When SEND_VALID=1 and SEND_READY=0, SEND_DATA, SEND_SOURCE, SEND_VALID and LAST shall all hold, and all RECEIVE_READY bits shall be 0.
REQ-022 A simultaneous output transfer and input transfer in the same cycle shall replace the register contents with no bubble.
REQ-023 Latency from input transfer to SEND_VALID=1 shall be exactly 1 cycle.
REQ-024 Pointer wrap: with LAST=CONNECT_NUM-1 the search shall start at index 0.
REQ-025 Fairness: a requester that holds RECEIVE_VALID high shall be granted within CONNECT_NUM accepted transfers.
REQ-026 A requester shall hold VALID and DATA stable until it is accepted; the block need not tolerate withdrawal of VALID.
REQ-027 SEND_DATA and SEND_SOURCE are don't-care while SEND_VALID=0, but they shall keep their last values, with no X after reset.

Reset
REQ-028 While RST=1 at a rising edge, the block shall set SEND_VALID <= 0, SEND_DATA <= 0, SEND_SOURCE <= 0 and LAST <= CONNECT_NUM-1.
REQ-029 While RST=1, all RECEIVE_READY bits shall be 0.
REQ-030 A reset asserted mid-operation shall discard any held packet without emitting it; the first grant after reset shall search from index 0.

Verification (CONNECT_NUM=3, random 192-bit packets)
REQ-031 Stimulus: RST=1 for 1 cycle -> SEND_VALID=0, RECEIVE_READY=3'b000, SEND_SOURCE=0.
REQ-032 Stimulus: after reset, all three requesters valid simultaneously and SEND_READY=1 -> outputs in order source 0,1,2, one per cycle, starting 1 cycle after the first accept, with SEND_DATA equal to each requester's packet.
REQ-033 Stimulus: only requester 1 valid continuously, SEND_READY=1 -> back-to-back grants to 1 with RECEIVE_READY=3'b010 every cycle and throughput of 1 packet per cycle.
REQ-034 Stimulus: SEND_VALID=1 holding a source-2 packet and SEND_READY=0 for 5 cycles while requesters 0 and 1 are valid -> RECEIVE_READY=0, SEND_DATA stable; when SEND_READY=1, requester 0 is granted (LAST=2 wraps to 0), then requester 1.
REQ-035 Stimulus: LAST=0 with requesters 0 and 2 valid -> grant 2, then 0; never grant 0 twice while 2 is waiting.
REQ-036 Stimulus: RST=1 while SEND_VALID=1 and SEND_READY=0 -> next cycle SEND_VALID=0, and the held packet is never observed; subsequent requests from 1 and 0 are served 0 first.

Source files
------------

// File: rtl/connect_arbiter.sv
// Round-robin arbiter merging CONNECT_NUM valid/ready packet streams into a
// single registered output stage tagged with the supplying requester index.
module connect_arbiter #(
  parameter int  DATA_WIDTH  = 192,
  parameter int  CONNECT_NUM = 3,
  localparam int SRC_WIDTH   = (CONNECT_NUM > 2) ? $clog2(CONNECT_NUM) : 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
  output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
  output logic                              SEND_VALID,
  input  logic                              SEND_READY,
  output logic [DATA_WIDTH-1:0]             SEND_DATA,
  output logic [SRC_WIDTH-1:0]              SEND_SOURCE
);

  logic                  accept;
  logic                  grant_found;
  logic [SRC_WIDTH-1:0]  grant_idx;
  logic [SRC_WIDTH-1:0]  last;
  logic [DATA_WIDTH-1:0] grant_data;

  // The output slot is free when empty or being drained this very cycle.
  assign accept = !SEND_VALID || SEND_READY;

  // Search last+1, last+2, ... wrapping, with last itself examined final.
  always_comb begin
    logic [SRC_WIDTH-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = last;
    for (int k = 0; k < CONNECT_NUM; k++) begin
      idx = (idx == SRC_WIDTH'(CONNECT_NUM - 1)) ? '0 : idx + 1'b1;
      if (!grant_found && RECEIVE_VALID[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (grant_idx == SRC_WIDTH'(i)) begin
        grant_data = RECEIVE_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    RECEIVE_READY = '0;
    if (accept && !RST && grant_found) begin
      RECEIVE_READY[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SEND_VALID  <= 1'b0;
      SEND_DATA   <= '0;
      SEND_SOURCE <= '0;
      last        <= SRC_WIDTH'(CONNECT_NUM - 1);
    end else if (accept) begin
      if (grant_found) begin
        SEND_VALID  <= 1'b1;
        SEND_DATA   <= grant_data;
        SEND_SOURCE <= grant_idx;
        last        <= grant_idx;
      end else begin
        // accept implies the held packet (if any) leaves this edge
        SEND_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_connect_arbiter.sv
// Bench for connect_arbiter: directed scenarios followed by random traffic,
// all checked against a rule-level round-robin model.
module tb_connect_arbiter;

  localparam int N  = 3;
  localparam int DW = 192;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    recv_valid;
  logic [N-1:0]    recv_ready;
  logic [DW*N-1:0] recv_data;
  logic            send_valid;
  logic            send_ready;
  logic [DW-1:0]   send_data;
  logic [1:0]      send_source;

  connect_arbiter #(.DATA_WIDTH(DW), .CONNECT_NUM(N)) dut (
    .CLK(clk), .RST(rst),
    .RECEIVE_VALID(recv_valid), .RECEIVE_READY(recv_ready), .RECEIVE_DATA(recv_data),
    .SEND_VALID(send_valid), .SEND_READY(send_ready),
    .SEND_DATA(send_data), .SEND_SOURCE(send_source)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // requester-side stimulus
  logic [DW-1:0] pkt [N];
  bit            v   [N];
  int            mode;   // 0: drop valid on accept, 1: keep valid with new packet, 2: random

  // reference model state
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_src   = 0;
  int            m_last  = N - 1;
  int            wait_cnt [N];

  function automatic logic [DW-1:0] rand_pkt();
    logic [DW-1:0] p;
    for (int j = 0; j < DW/32; j++) p[j*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      recv_data[i*DW +: DW] = pkt[i];
      recv_valid[i]         = v[i];
    end
  endtask

  task automatic tick();
    int         g;
    bit         acc;
    logic [N-1:0] er;
    @(negedge clk);
    g   = model_grant();
    acc = !m_valid || send_ready;
    er  = (acc && !rst && g >= 0) ? N'(1 << g) : '0;
    checks++;
    assert (recv_ready === er) else begin
      errors++;
      $error("FAIL recv_ready observed=%b expected=%b", recv_ready, er);
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else if (acc) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = pkt[g]; m_src = g; m_last = g;
        checks++;
        assert (wait_cnt[g] <= N - 1) else begin
          errors++;
          $error("FAIL fairness port=%0d waited=%0d limit=%0d", g, wait_cnt[g], N - 1);
        end
        for (int i = 0; i < N; i++) begin
          if (i == g) wait_cnt[i] = 0;
          else if (v[i]) wait_cnt[i]++;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    checks++;
    assert (send_valid === m_valid) else begin
      errors++;
      $error("FAIL send_valid observed=%b expected=%b", send_valid, m_valid);
    end
    checks++;
    assert (send_data === m_data) else begin
      errors++;
      $error("FAIL send_data observed=%h expected=%h", send_data, m_data);
    end
    checks++;
    assert (send_source === 2'(m_src)) else begin
      errors++;
      $error("FAIL send_source observed=%0d expected=%0d", send_source, m_src);
    end
    if (er != '0) begin
      case (mode)
        0: v[g] = 1'b0;
        1: pkt[g] = rand_pkt();
        default: begin
          pkt[g] = rand_pkt();
          v[g]   = ($urandom % 2) == 0;
        end
      endcase
    end
    apply();
  endtask

  task automatic set_valid(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[i] && !v[i]) pkt[i] = rand_pkt();
      v[i] = mask[i];
    end
    apply();
  endtask

  initial begin
    logic [DW-1:0] first_pkt [N];
    logic [DW-1:0] held;
    mode = 0;
    for (int i = 0; i < N; i++) begin
      pkt[i] = rand_pkt(); v[i] = 1'b0; wait_cnt[i] = 0;
    end
    rst = 1'b1; send_ready = 1'b0;
    apply();

    // reset state
    tick();
    rst = 1'b0;

    // all three valid after reset: served 0, 1, 2 back to back
    send_ready = 1'b1;
    set_valid(3'b111);
    for (int i = 0; i < N; i++) first_pkt[i] = pkt[i];
    for (int s = 0; s < N; s++) begin
      tick();
      checks++;
      assert (send_source === 2'(s) && send_data === first_pkt[s]) else begin
        errors++;
        $error("FAIL order step=%0d observed_src=%0d expected_src=%0d", s, send_source, s);
      end
    end
    tick();

    // requester 1 alone, continuously valid: one packet per cycle
    mode = 1;
    set_valid(3'b010);
    repeat (5) tick();
    mode = 0;
    v[1] = 1'b0;

    // source-2 packet held under backpressure while 0 and 1 wait
    set_valid(3'b100);
    tick();
    held = send_data;
    send_ready = 1'b0;
    set_valid(3'b011);
    repeat (5) tick();
    checks++;
    assert (send_data === held && send_source === 2'd2) else begin
      errors++;
      $error("FAIL hold observed_src=%0d expected_src=2", send_source);
    end
    send_ready = 1'b1;
    tick();
    checks++;
    assert (send_source === 2'd0) else begin
      errors++;
      $error("FAIL wrap observed_src=%0d expected_src=0", send_source);
    end
    repeat (2) tick();

    // last=0 with 0 and 2 valid: 2 first, then 0
    set_valid(3'b001);
    tick();
    set_valid(3'b101);
    tick();
    checks++;
    assert (send_source === 2'd2) else begin
      errors++;
      $error("FAIL skip observed_src=%0d expected_src=2", send_source);
    end
    repeat (2) tick();

    // reset while a packet is held: it is dropped, next search starts at 0
    send_ready = 1'b0;
    set_valid(3'b001);
    tick();
    set_valid(3'b000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_ready = 1'b1;
    set_valid(3'b011);
    tick();
    checks++;
    assert (send_valid === 1'b1 && send_source === 2'd0) else begin
      errors++;
      $error("FAIL post_reset observed_src=%0d expected_src=0", send_source);
    end
    repeat (2) tick();

    // random traffic with backpressure and occasional reset
    mode = 2;
    for (int n = 0; n < 400; n++) begin
      tick();
      send_ready = ($urandom % 4) != 0;
      rst        = ($urandom % 64) == 0;
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 3) == 0) begin
          v[i] = 1'b1; pkt[i] = rand_pkt();
        end
      end
      apply();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
